// File: rtl/dmem_mmio.sv
// Data-side responder for the single-cycle MIPS core: 60-word RAM plus
// cycle counter, dropped-push counter, TX push port and status word.
module dmem_mmio #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  addr,
  input  logic        wr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [5:0] A_CYC  = 6'd60;
  localparam logic [5:0] A_DROP = 6'd61;
  localparam logic [5:0] A_TXD  = 6'd62;
  localparam logic [5:0] A_STAT = 6'd63;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   ram [0:59];
  logic [31:0]   fifo_mem [0:DEPTH-1];
  logic [31:0]   cyc;
  logic [31:0]   drop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        full;
  logic        empty;
  logic        push_req;
  logic        push;
  logic        pop;
  logic [31:0] stat;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_req = wr && (addr == A_TXD);
  assign push     = push_req && !full;
  assign pop      = !empty && tx_ready;

  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];
  assign stat     = {22'd0, empty, full, 8'(count)};

  // RAM and FIFO storage carry no reset so a reset never disturbs program data.
  always_ff @(posedge clk) begin
    if (wr && (addr < A_CYC))
      ram[addr] <= din;
    if (push)
      fifo_mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc <= '0;
    end else if (wr && (addr == A_CYC)) begin
      cyc <= '0;
    end else begin
      cyc <= cyc + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop <= '0;
    end else if (wr && (addr == A_DROP)) begin
      drop <= '0;
    end else if (push_req && full) begin
      drop <= sat_inc(drop);
    end
  end

  // Push and pop are both judged on the pre-edge count, so a full FIFO
  // that pops in the same cycle still drops the push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    if (addr < A_CYC) begin
      dout = ram[addr];
    end else begin
      case (addr)
        A_CYC:   dout = cyc;
        A_DROP:  dout = drop;
        A_STAT:  dout = stat;
        default: dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed and randomized bench for dmem_mmio against a queue-based
// reference model of the address map and TX FIFO.
module tb_dmem_mmio;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [5:0]  addr;
  logic        wr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  dmem_mmio #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wr       (wr),
    .din      (din),
    .dout     (dout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [31:0] ram_m   [0:59];
  bit          ram_set [0:59];
  logic [31:0] cyc_m;
  logic [31:0] drop_m;
  logic [31:0] q_m [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_m();
    int c = q_m.size();
    return {22'd0, (c == 0), (c == DEPTH), 8'(c)};
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".tx_valid"}, {31'd0, tx_valid}, {31'd0, q_m.size() != 0});
    if (q_m.size() != 0)
      chk({tag, ".tx_data"}, tx_data, q_m[0]);
    if (addr < 6'd60) begin
      if (ram_set[addr])
        chk({tag, ".ram"}, dout, ram_m[addr]);
    end else begin
      case (addr)
        6'd60:   chk({tag, ".cyc"},  dout, cyc_m);
        6'd61:   chk({tag, ".drop"}, dout, drop_m);
        6'd62:   chk({tag, ".txd"},  dout, 32'd0);
        default: chk({tag, ".stat"}, dout, stat_m());
      endcase
    end
  endtask

  // Advance the model by one rising edge using the current inputs, then
  // wait for that edge.
  task automatic tick();
    int  c;
    bit  push_req;
    c = q_m.size();
    push_req = wr && (addr == 6'd62);
    if (wr && addr < 6'd60) begin
      ram_m[addr]   = din;
      ram_set[addr] = 1'b1;
    end
    if (rst) begin
      cyc_m = (wr && addr == 6'd60) ? 32'd0 : cyc_m + 32'd1;
      if (wr && addr == 6'd61)
        drop_m = 32'd0;
      else if (push_req && c == DEPTH && drop_m != 32'hFFFF_FFFF)
        drop_m = drop_m + 32'd1;
      if (c != 0 && tx_ready)
        void'(q_m.pop_front());
      if (push_req && c < DEPTH)
        q_m.push_back(din);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string tag, input logic w, input logic [5:0] a,
                       input logic [31:0] d, input logic rdy);
    wr = w; addr = a; din = d; tx_ready = rdy;
    #1;
    check_state(tag);
    tick();
  endtask

  task automatic model_reset();
    cyc_m  = 32'd0;
    drop_m = 32'd0;
    q_m.delete();
  endtask

  initial begin
    for (int i = 0; i < 60; i++) ram_set[i] = 1'b0;
    model_reset();
    rst = 1'b0; wr = 1'b0; addr = 6'd63; din = '0; tx_ready = 1'b0;

    // Reset hold
    repeat (3) tick();
    addr = 6'd63; #1;
    chk("rst.tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst.stat", dout, 32'h200);
    addr = 6'd60; #1;
    chk("rst.cyc", dout, 32'd0);

    // Release away from the edge, then count 10 edges
    #1 rst = 1'b1;
    repeat (10) tick();
    addr = 6'd60; #1;
    chk("cyc.after10", dout, 32'd10);
    check_state("cyc.model");

    // RAM write/readback, including same-cycle old value
    cycle("ram.w5", 1'b1, 6'd5, 32'hDEADBEEF, 1'b0);
    cycle("ram.w59", 1'b1, 6'd59, 32'h1, 1'b0);
    addr = 6'd5; wr = 1'b0; #1;
    chk("ram.r5", dout, 32'hDEADBEEF);
    addr = 6'd59; #1;
    chk("ram.r59", dout, 32'h1);
    wr = 1'b1; addr = 6'd5; din = 32'h12345678; #1;
    chk("ram.old_same_cycle", dout, 32'hDEADBEEF);
    tick();
    wr = 1'b0; #1;
    chk("ram.new", dout, 32'h12345678);

    // CYC write loads 0, then counts
    cycle("cyc.w", 1'b1, 6'd60, 32'h55, 1'b0);
    wr = 1'b0; addr = 6'd60; #1;
    chk("cyc.after_write", dout, 32'd0);
    tick();
    chk("cyc.next", dout, 32'd1);

    // Wrap from all ones
    force dut.cyc = 32'hFFFF_FFFF;
    #1 release dut.cyc;
    cyc_m = 32'hFFFF_FFFF;
    #1;
    chk("cyc.forced", dout, 32'hFFFF_FFFF);
    tick();
    chk("cyc.wrap", dout, 32'd0);

    // Fill and overflow with tx_ready low
    for (int i = 0; i < 6; i++)
      cycle("fill", 1'b1, 6'd62, 32'hA0 + 32'(i), 1'b0);
    wr = 1'b0; addr = 6'd63; #1;
    chk("fill.stat", dout, 32'h104);
    addr = 6'd61; #1;
    chk("fill.drop", dout, 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("fill.head", tx_data, 32'hA0);
      chk("fill.valid", {31'd0, tx_valid}, 32'd1);
      tick();
    end
    cycle("drop.w", 1'b1, 6'd61, 32'h77, 1'b0);
    wr = 1'b0; addr = 6'd61; #1;
    chk("drop.cleared", dout, 32'd0);

    // Drain
    tx_ready = 1'b1; addr = 6'd63;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain.data", tx_data, 32'hA0 + 32'(i));
      chk("drain.valid", {31'd0, tx_valid}, 32'd1);
      tick();
    end
    #1;
    chk("drain.empty", {31'd0, tx_valid}, 32'd0);
    chk("drain.stat", dout, 32'h200);
    check_state("drain.model");

    // Push+pop while full: push dropped, count falls to 3
    for (int i = 0; i < 4; i++)
      cycle("sim.fill", 1'b1, 6'd62, 32'hC0 + 32'(i), 1'b0);
    cycle("sim.fullpp", 1'b1, 6'd62, 32'hB0, 1'b1);
    wr = 1'b0; addr = 6'd61; #1;
    chk("sim.drop", dout, 32'd1);
    addr = 6'd63; #1;
    chk("sim.stat3", dout, 32'h003);
    cycle("sim.pop", 1'b0, 6'd63, 32'h0, 1'b1);
    cycle("sim.pp2", 1'b1, 6'd62, 32'hB1, 1'b1);
    wr = 1'b0; addr = 6'd63; tx_ready = 1'b0; #1;
    chk("sim.stat2", dout, 32'h002);
    chk("sim.head", tx_data, 32'hC3);
    for (int i = 0; i < 2; i++)
      cycle("sim.drain", 1'b0, 6'd63, 32'h0, 1'b1);
    #1;
    check_state("sim.after");

    // Queue 3 words, then reset asynchronously mid-cycle
    for (int i = 0; i < 3; i++)
      cycle("mid.fill", 1'b1, 6'd62, 32'hE0 + 32'(i), 1'b0);
    wr = 1'b0; addr = 6'd63; tx_ready = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("mid.tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid.stat", dout, 32'h200);
    #1 rst = 1'b1;
    addr = 6'd5; #1;
    chk("mid.ram5", dout, 32'h12345678);
    addr = 6'd59; #1;
    chk("mid.ram59", dout, 32'h1);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  a;
      logic        w;
      logic        rdy;
      if ($urandom_range(0, 7) < 5)
        a = 6'(60 + $urandom_range(0, 3));
      else
        a = 6'($urandom_range(0, 59));
      w   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 1) == 1);
      cycle("rand", w, a, $urandom, rdy);
    end
    addr = 6'd63; wr = 1'b0; #1;
    check_state("rand.final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
